lfsr_prbs: RTL and testbench



---
 rtl/lfsr_prbs_pkg.sv | 34 +++
 rtl/lfsr_prbs_chk.sv | 127 ++++++++++++
 rtl/lfsr_prbs.sv | 110 +++++++++++
 tb/tb_lfsr_prbs.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_prbs_pkg.sv
// Shared types and LFSR math for the PRBS generator and checker.
// Values are carried zero-extended to MAX_W bits so one function serves every WIDTH.
package lfsr_prbs_pkg;

   localparam int MAX_W = 64;
   localparam logic [MAX_W-1:0] ONE = 64'd1;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   // One Galois step: shift up, and fold the old MSB into stage 0 and every tap stage.
   function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] q,
                                                  input logic [MAX_W-1:0] poly,
                                                  input int width);
      logic [MAX_W-1:0] msb;
      logic [MAX_W-1:0] mask;
      logic [MAX_W-1:0] n;
      msb  = ONE << (width - 1);
      mask = (msb << 1) - ONE;
      n    = (q << 1) & mask;
      if ((q & msb) != '0) n = n ^ ((poly | ONE) & mask);
      return n;
   endfunction

   // Expected next bit. hist[k] holds s[n-W+k] (bit W-1 is the newest), so the
   // recurrence taps {0} U POLY line up directly with hist bit positions.
   function automatic logic lfsr_pred(input logic [MAX_W-1:0] hist,
                                      input logic [MAX_W-1:0] poly);
      return ^(hist & (poly | ONE));
   endfunction

endpackage

// File: rtl/lfsr_prbs_chk.sv
// Self-synchronising PRBS checker: history register, HUNT/LOCKED FSM and error counters.
module lfsr_prbs_chk
   import lfsr_prbs_pkg::*;
#(
   parameter int unsigned          WIDTH     = 26,
   parameter logic [WIDTH-1:0]     POLY      = 26'h0000182,
   parameter int unsigned          STEP      = 1,
   parameter int unsigned          LOCK_CNT  = 32,
   parameter int unsigned          LOSS_ERRS = 4,
   parameter int unsigned          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             chk_vld,
   input  logic [STEP-1:0]  chk_din,
   input  logic             chk_clr,
   output logic             chk_lock,
   output logic             chk_err,
   output logic [CNT_W-1:0] chk_err_cnt
);

   localparam int FILL_W = $clog2(WIDTH + 1);
   localparam int RUN_W  = $clog2(LOCK_CNT + 1);
   localparam int ACC_W  = $clog2(LOSS_ERRS + 1);
   localparam logic [MAX_W-1:0] POLY_X = MAX_W'(POLY);

   chk_state_e       state_q, state_d;
   logic [WIDTH-1:0] hist_q, hist_d;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             lock_q;
   logic             err_q, err_d;

   // Walk the word bit-serially, oldest first; decide state transitions at word end.
   always_comb begin
      logic [STEP-1:0] din_sh;
      logic            bit_in;
      logic            exp_bit;
      logic            miss;
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      run_d   = run_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      din_sh  = chk_din;
      bit_in  = 1'b0;
      exp_bit = 1'b0;
      miss    = 1'b0;
      if (chk_vld) begin
         for (int k = 0; k < STEP; k++) begin
            bit_in  = din_sh[STEP-1];
            din_sh  = din_sh << 1;
            exp_bit = lfsr_pred(MAX_W'(hist_d), POLY_X);
            if (state_q == HUNT) begin
               if (fill_d < FILL_W'(WIDTH)) begin
                  fill_d = fill_d + FILL_W'(1);
               end else if (bit_in == exp_bit) begin
                  if (run_d != '1) run_d = run_d + RUN_W'(1);
               end else begin
                  run_d = '0;
               end
            end else begin
               if (bit_in != exp_bit) begin
                  miss  = 1'b1;
                  run_d = '0;
                  if (acc_d != '1) acc_d = acc_d + ACC_W'(1);
                  if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
               end else begin
                  if (run_d != '1) run_d = run_d + RUN_W'(1);
                  if (run_d >= RUN_W'(LOCK_CNT)) acc_d = '0;
               end
            end
            // every bit enters the history, matched or not
            hist_d = {bit_in, hist_d[WIDTH-1:1]};
         end
         if (state_q == HUNT) begin
            if (run_d >= RUN_W'(LOCK_CNT)) begin
               state_d = LOCKED;
               run_d   = '0;
               acc_d   = '0;
            end
         end else begin
            err_d = miss;
            if (acc_d >= ACC_W'(LOSS_ERRS)) begin
               state_d = HUNT;
               fill_d  = '0;
               run_d   = '0;
               acc_d   = '0;
            end
         end
      end
      // clear wins over errors counted in the same cycle
      if (chk_clr) cnt_d = '0;
   end

   // Checker state register; lock flag registered from the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= HUNT;
         hist_q  <= '0;
         fill_q  <= '0;
         run_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         lock_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         run_q   <= run_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         lock_q  <= (state_d == LOCKED);
         err_q   <= err_d;
      end
   end

   assign chk_lock    = lock_q;
   assign chk_err     = err_q;
   assign chk_err_cnt = cnt_q;

endmodule

// File: rtl/lfsr_prbs.sv
// Galois LFSR PRBS generator (STEP bits per clock) with an attached PRBS checker.
// Optional build macro LFSR_PRBS_ERR_INJ_EN adds input err_inj, which inverts the
// oldest output bit of an enabled cycle without disturbing the LFSR state.
module lfsr_prbs
   import lfsr_prbs_pkg::*;
#(
   parameter int unsigned      WIDTH     = 26,
   parameter logic [WIDTH-1:0] POLY      = 26'h0000182,
   parameter int unsigned      STEP      = 1,
   parameter int unsigned      LOCK_CNT  = 32,
   parameter int unsigned      LOSS_ERRS = 4,
   parameter int unsigned      CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
`ifdef LFSR_PRBS_ERR_INJ_EN
   input  logic             err_inj,
`endif
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] q,
   output logic [STEP-1:0]  dout,
   output logic             dout_vld,
   input  logic             chk_vld,
   input  logic [STEP-1:0]  chk_din,
   input  logic             chk_clr,
   output logic             chk_lock,
   output logic             chk_err,
   output logic [CNT_W-1:0] chk_err_cnt
);

   localparam logic [MAX_W-1:0] POLY_X = MAX_W'(POLY);

   logic [WIDTH-1:0] state_q, state_d;
   logic [STEP-1:0]  dout_q, dout_d;
   logic             vld_q, vld_d;
   logic [WIDTH-1:0] adv_state;
   logic [STEP-1:0]  adv_bits;

   // Unrolled STEP-step advance; each step emits the pre-step MSB, oldest ends in dout MSB.
   always_comb begin
      logic [MAX_W-1:0] s;
      s        = MAX_W'(state_q);
      adv_bits = '0;
      for (int k = 0; k < STEP; k++) begin
         adv_bits = (adv_bits << 1) | STEP'(s[WIDTH-1]);
         s        = lfsr_step(s, POLY_X, WIDTH);
      end
      adv_state = s[WIDTH-1:0];
   end

   // Next generator state: load beats enable, and an all-zero state is recovered on enable.
   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      if (load) begin
         state_d = (seed == '0) ? WIDTH'(1) : seed;
      end else if (en) begin
         vld_d = 1'b1;
         if (state_q == '0) begin
            state_d = WIDTH'(1);
            dout_d  = '0;
         end else begin
            state_d = adv_state;
            dout_d  = adv_bits;
         end
`ifdef LFSR_PRBS_ERR_INJ_EN
         if (err_inj) dout_d[STEP-1] = ~dout_d[STEP-1];
`endif
      end
   end

   // Generator registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= WIDTH'(1);
         dout_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
      end
   end

   assign q        = state_q;
   assign dout     = dout_q;
   assign dout_vld = vld_q;

   lfsr_prbs_chk #(
      .WIDTH     (WIDTH),
      .POLY      (POLY),
      .STEP      (STEP),
      .LOCK_CNT  (LOCK_CNT),
      .LOSS_ERRS (LOSS_ERRS),
      .CNT_W     (CNT_W)
   ) u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .chk_vld     (chk_vld),
      .chk_din     (chk_din),
      .chk_clr     (chk_clr),
      .chk_lock    (chk_lock),
      .chk_err     (chk_err),
      .chk_err_cnt (chk_err_cnt)
   );

endmodule

// File: tb/tb_lfsr_prbs.sv
// Directed bench for lfsr_prbs: 4-bit period, load/reset, 8-bit parallel step,
// checker lock, error counting, loss/relock and counter clear.
module tb_lfsr_prbs;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   n_total = 0;
   int   n_bad   = 0;

   // 4-bit instance
   logic       en4, load4;
   logic [3:0] seed4, q4;
   logic [0:0] dout4;
   logic       vld4, lock4, err4;
   logic [15:0] cnt4;

   // 26-bit, 8 bits per clock, looped back
   logic        en8;
   logic [25:0] q8;
   logic [7:0]  dout8;
   logic        vld8, lock8, err8;
   logic [15:0] cnt8;

   // 26-bit STEP=1 main instance, looped back through a bit flipper
   logic        en1, flip, clr, inj1;
   logic [25:0] q1;
   logic [0:0]  dout1, din1;
   logic        vld1, lock1, err1;
   logic [15:0] cnt1;

   // second checker with LOSS_ERRS=16 fed with the same stream
   logic [25:0] ql;
   logic [0:0]  doutl;
   logic        vldl, lockl, errl;
   logic [15:0] cntl;

   assign din1 = dout1 ^ flip;

   lfsr_prbs #(.WIDTH(4), .POLY(4'h2), .STEP(1)) u_w4 (
      .clk(clk), .rst_n(rst_n), .en(en4), .load(load4),
`ifdef LFSR_PRBS_ERR_INJ_EN
      .err_inj(1'b0),
`endif
      .seed(seed4), .q(q4), .dout(dout4), .dout_vld(vld4),
      .chk_vld(1'b0), .chk_din(1'b0), .chk_clr(1'b0),
      .chk_lock(lock4), .chk_err(err4), .chk_err_cnt(cnt4)
   );

   lfsr_prbs #(.STEP(8)) u_s8 (
      .clk(clk), .rst_n(rst_n), .en(en8), .load(1'b0),
`ifdef LFSR_PRBS_ERR_INJ_EN
      .err_inj(1'b0),
`endif
      .seed(26'h0), .q(q8), .dout(dout8), .dout_vld(vld8),
      .chk_vld(vld8), .chk_din(dout8), .chk_clr(1'b0),
      .chk_lock(lock8), .chk_err(err8), .chk_err_cnt(cnt8)
   );

   lfsr_prbs u_dut (
      .clk(clk), .rst_n(rst_n), .en(en1), .load(1'b0),
`ifdef LFSR_PRBS_ERR_INJ_EN
      .err_inj(inj1),
`endif
      .seed(26'h0), .q(q1), .dout(dout1), .dout_vld(vld1),
      .chk_vld(vld1), .chk_din(din1), .chk_clr(clr),
      .chk_lock(lock1), .chk_err(err1), .chk_err_cnt(cnt1)
   );

   lfsr_prbs #(.LOSS_ERRS(16)) u_l16 (
      .clk(clk), .rst_n(rst_n), .en(1'b0), .load(1'b0),
`ifdef LFSR_PRBS_ERR_INJ_EN
      .err_inj(1'b0),
`endif
      .seed(26'h0), .q(ql), .dout(doutl), .dout_vld(vldl),
      .chk_vld(vld1), .chk_din(din1), .chk_clr(clr),
      .chk_lock(lockl), .chk_err(errl), .chk_err_cnt(cntl)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // independent shift-register form of the 26-bit LFSR, taps 0x182 plus stage 0
   function automatic logic [25:0] mstep(input logic [25:0] s);
      return {s[24:0], 1'b0} ^ (s[25] ? 26'h0000183 : 26'h0);
   endfunction

   logic [14:0] pat;
   logic [25:0] m;
   logic [7:0]  w;
   logic        e_d, e_l;
   int          pulses;

   initial begin
      rst_n = 1'b0; en4 = 1'b0; load4 = 1'b0; seed4 = 4'h0;
      en8 = 1'b0; en1 = 1'b0; flip = 1'b0; clr = 1'b0; inj1 = 1'b0;
      pulses = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_q4", 64'(q4), 64'd1);
      check("rst_dout4", 64'(dout4), 64'd0);
      check("rst_vld4", 64'(vld4), 64'd0);
      check("rst_lock4", 64'(lock4), 64'd0);
      check("rst_err4", 64'(err4), 64'd0);
      check("rst_cnt4", 64'(cnt4), 64'd0);
      check("rst_q8", 64'(q8), 64'd1);
      check("rst_q1", 64'(q1), 64'd1);
      check("rst_lock1", 64'(lock1), 64'd0);
      check("rst_err1", 64'(err1), 64'd0);
      check("rst_cnt1", 64'(cnt1), 64'd0);
      check("rst_ql", 64'(ql), 64'd1);
      check("rst_doutl", 64'(doutl), 64'd0);
      check("rst_vldl", 64'(vldl), 64'd0);
      check("rst_lockl", 64'(lockl), 64'd0);
      check("rst_errl", 64'(errl), 64'd0);
      check("rst_cntl", 64'(cntl), 64'd0);
      rst_n = 1'b1;

      // full period of the 4-bit sequence
      pat = 15'b000100110101111;
      en4 = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick;
         check("w4_dout", 64'(dout4), 64'(pat[14-i]));
      end
      check("w4_vld", 64'(vld4), 64'd1);
      check("w4_period_q", 64'(q4), 64'd1);
      repeat (4) tick;
      check("w4_q_after4", 64'(q4), 64'd3);
      check("w4_dout_after4", 64'(dout4), 64'd1);

      // load with zero seed while en is high: load wins, dout holds
      load4 = 1'b1; seed4 = 4'h0;
      tick;
      check("load0_q", 64'(q4), 64'd1);
      check("load0_vld", 64'(vld4), 64'd0);
      check("load0_dout", 64'(dout4), 64'd1);
      seed4 = 4'h9;
      tick;
      check("load9_q", 64'(q4), 64'd9);
      load4 = 1'b0; en4 = 1'b0;
      tick;
      check("idle_q", 64'(q4), 64'd9);
      check("idle_vld", 64'(vld4), 64'd0);
      check("idle_dout", 64'(dout4), 64'd1);
      en4 = 1'b1;
      tick;
      check("step9_q", 64'(q4), 64'd1);
      check("step9_dout", 64'(dout4), 64'd1);
      check("step9_vld", 64'(vld4), 64'd1);
      tick;
      check("step1_q", 64'(q4), 64'd2);

      // asynchronous reset in mid-cycle
      #2 rst_n = 1'b0;
      #1;
      check("arst_q4", 64'(q4), 64'd1);
      check("arst_vld4", 64'(vld4), 64'd0);
      en4 = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;

      // 8 bits per clock against the serial model, then checker lock on words
      m = 26'd1;
      en8 = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick;
         if (k <= 6) begin
            w = 8'h0;
            for (int b = 0; b < 8; b++) begin
               w = {w[6:0], m[25]};
               m = mstep(m);
            end
            check("s8_dout", 64'(dout8), 64'(w));
            check("s8_q", 64'(q8), 64'(m));
         end
         if (k == 1) check("s8_q_w1", 64'(q8), 64'h100);
         if (k == 3) check("s8_q_w3", 64'(q8), 64'h1000000);
         if (k == 4) begin
            check("s8_dout_w4", 64'(dout8), 64'h40);
            check("s8_q_w4", 64'(q8), 64'h60C0);
         end
         if (k == 8) check("s8_lock_early", 64'(lock8), 64'd0);
         if (k == 9) check("s8_lock", 64'(lock8), 64'd1);
      end
      check("s8_cnt", 64'(cnt8), 64'd0);
      check("s8_err", 64'(err8), 64'd0);
      en8 = 1'b0;

      // serial lock after 26 fill + 32 clean bits
      en1 = 1'b1;
      repeat (58) tick;
      check("lock_early", 64'(lock1), 64'd0);
      check("lockl_early", 64'(lockl), 64'd0);
      tick;
      check("lock", 64'(lock1), 64'd1);
      check("lockl", 64'(lockl), 64'd1);
      check("lock_cnt", 64'(cnt1), 64'd0);
      check("lockl_cnt", 64'(cntl), 64'd0);
      repeat (40) tick;
      check("clean_cnt", 64'(cnt1), 64'd0);
      check("clean_lock", 64'(lock1), 64'd1);

      // one flipped bit: mismatches at n, n+18, n+19, n+25, n+26 (taps 0,1,7,8)
      flip = 1'b1;
      tick;
      flip = 1'b0;
      check("flip_err", 64'(err1), 64'd1);
      check("flip_cnt", 64'(cnt1), 64'd1);
      check("flipl_err", 64'(errl), 64'd1);
      check("flipl_cnt", 64'(cntl), 64'd1);
      for (int j = 1; j <= 30; j++) begin
         tick;
         e_d = (j == 18) || (j == 19) || (j == 25);
         e_l = e_d || (j == 26);
         check("echo_err", 64'(err1), 64'(e_d));
         check("echol_err", 64'(errl), 64'(e_l));
         check("echo_lock", 64'(lock1), 64'(j < 25));
      end
      check("loss_cnt", 64'(cnt1), 64'd4);
      check("lossl_cnt", 64'(cntl), 64'd5);
      check("lossl_lock", 64'(lockl), 64'd1);

      // relock 26+32 bits after the word that caused the loss
      repeat (52) tick;
      check("relock_early", 64'(lock1), 64'd0);
      tick;
      check("relock", 64'(lock1), 64'd1);
      check("relock_cnt", 64'(cnt1), 64'd4);

      clr = 1'b1;
      tick;
      clr = 1'b0;
      check("clr_cnt", 64'(cnt1), 64'd0);
      check("clrl_cnt", 64'(cntl), 64'd0);
      check("clr_lock", 64'(lock1), 64'd1);

      // no valid data: checker holds
      en1 = 1'b0;
      repeat (3) tick;
      check("hold_vld", 64'(vld1), 64'd0);
      check("hold_err", 64'(err1), 64'd0);
      check("hold_lock", 64'(lock1), 64'd1);
      check("hold_cnt", 64'(cnt1), 64'd0);
      en1 = 1'b1;
      repeat (40) tick;
      check("resume_lock", 64'(lock1), 64'd1);
      check("resume_cnt", 64'(cnt1), 64'd0);

`ifdef LFSR_PRBS_ERR_INJ_EN
      // one injected bit corrupts the stream once; the LFSR itself keeps going
      inj1 = 1'b1;
      tick;
      inj1 = 1'b0;
      pulses = 0;
      for (int j = 1; j <= 30; j++) begin
         tick;
         pulses += int'(errl);
      end
      check("inj_pulses", 64'(pulses), 64'd5);
      check("inj_cnt", 64'(cntl), 64'd5);
      check("inj_lock", 64'(lockl), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
